// File: rtl/crate_rom_arbiter_if.sv
// Requester-side bus of the shared crate/doghouse sprite ROM port.
// The master side is the draw/logic blocks plus the ROM; the slave side is the arbiter.
interface crate_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_rgb;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    starve_ovr;

  modport master (output req, addr, rom_rgb,
                  input  gnt, rom_addr, rd_valid, rd_data, starve_ovr);
  modport slave  (input  req, addr, rom_rgb,
                  output gnt, rom_addr, rd_valid, rd_data, starve_ovr);
endinterface

// File: rtl/crate_rom_arbiter.sv
// Sprite ROM read-port arbiter: requester 0 (pixel path) has fixed priority,
// the rest share round-robin, with a starvation guard against requester 0.
module crate_rom_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk60MHz,
  input  logic                rst_n,
  crate_rom_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [PTR_W-1:0]             rr_ptr, rr_next;
  logic [CNT_W-1:0]             starve_cnt;
  logic [N_REQ-1:0]             rr_req, rr_win, gnt_c;
  logic                         any_rr, ovr_c, rr_gnt;
  logic [ADDR_W-1:0]            rom_addr_c;
  logic [ROM_LAT:1][N_REQ-1:0]  vld_pipe;

  assign addr_v = bus.addr;
  assign rr_req = bus.req & ~N_REQ'(1);
  assign any_rr = |rr_req;

  // Rotating scan: the second pass (indices >= rr_ptr) overrides the wrapped
  // first pass, so the lowest index at or above rr_ptr wins when present.
  always_comb begin
    rr_win  = '0;
    rr_next = PTR_W'(1);
    for (int i = N_REQ-1; i >= 1; i--) begin
      if (rr_req[i]) begin
        rr_win  = N_REQ'(1) << i;
        rr_next = (i == N_REQ-1) ? PTR_W'(1) : PTR_W'(i + 1);
      end
    end
    for (int i = N_REQ-1; i >= 1; i--) begin
      if (rr_req[i] && i >= int'(rr_ptr)) begin
        rr_win  = N_REQ'(1) << i;
        rr_next = (i == N_REQ-1) ? PTR_W'(1) : PTR_W'(i + 1);
      end
    end
  end

  // Grant is forced off while reset is held so nothing is accepted.
  always_comb begin
    gnt_c = '0;
    ovr_c = 1'b0;
    if (rst_n) begin
      if (starve_cnt == CNT_MAX && any_rr) begin
        gnt_c = rr_win;
        ovr_c = 1'b1;
      end else if (bus.req[0]) begin
        gnt_c = N_REQ'(1);
      end else begin
        gnt_c = rr_win;
      end
    end
  end

  assign rr_gnt = |(gnt_c & ~N_REQ'(1));

  always_comb begin
    rom_addr_c = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt_c[i]) rom_addr_c = addr_v[i];
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= PTR_W'(1);
      starve_cnt <= '0;
      vld_pipe   <= '0;
    end else begin
      if (rr_gnt) rr_ptr <= rr_next;
      if (rr_gnt || !any_rr)
        starve_cnt <= '0;
      else if (gnt_c[0] && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + CNT_W'(1);
      vld_pipe[1] <= gnt_c;
      for (int s = 2; s <= ROM_LAT; s++)
        vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.rom_addr   = rom_addr_c;
  assign bus.starve_ovr = ovr_c;
  assign bus.rd_valid   = vld_pipe[ROM_LAT];
  assign bus.rd_data    = bus.rom_rgb;
endmodule

// File: tb/tb_crate_rom_arbiter.sv
// Bench for crate_rom_arbiter: per-cycle grant vectors plus a read-return scoreboard.
module tb_crate_rom_arbiter;
  localparam int N_REQ = 4, ADDR_W = 12, DATA_W = 12, ROM_LAT = 1, STARVE_MAX = 8;

  logic clk60MHz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk60MHz = ~clk60MHz;

  crate_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  crate_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .ROM_LAT(ROM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk60MHz (clk60MHz),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rom_pipe [1:ROM_LAT];
  always @(posedge clk60MHz) begin
    rom_pipe[1] <= rom[bus.rom_addr];
    for (int s = 2; s <= ROM_LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign bus.rom_rgb = rom_pipe[ROM_LAT];

  typedef struct { logic [N_REQ-1:0] v; logic [DATA_W-1:0] d; } sb_t;
  typedef struct { logic [N_REQ-1:0] req; logic [N_REQ-1:0] gnt; logic ovr; } vec_t;
  sb_t  sb[$];
  vec_t vt[$];
  logic [N_REQ-1:0][ADDR_W-1:0] cur_addr;
  int checks = 0, errors = 0, pops = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Return-path monitor: every rd_valid pulse must match the oldest expected read.
  always @(negedge clk60MHz) begin
    if (bus.rd_valid != '0) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 32'(bus.rd_valid), 32'(0));
      end else begin
        sb_t e;
        e = sb.pop_front();
        pops++;
        check("rd_valid", 32'(bus.rd_valid), 32'(e.v));
        check("rd_data", 32'(bus.rd_data), 32'(e.d));
      end
    end
  end

  // Called at posedge+1: drive, check mid-cycle, queue the expected return.
  task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] eg,
                      input logic eo, input string nm);
    logic [ADDR_W-1:0] ea;
    ea = '0;
    for (int i = 0; i < N_REQ; i++) if (eg[i]) ea = cur_addr[i];
    bus.req  = r;
    bus.addr = cur_addr;
    @(negedge clk60MHz);
    check({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
    check({nm, "_rom_addr"}, 32'(bus.rom_addr), 32'(ea));
    check({nm, "_ovr"}, 32'(bus.starve_ovr), 32'(eo));
    if (eg != '0) sb.push_back('{eg, rom[ea]});
    @(posedge clk60MHz); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    for (int i = 0; i < (1<<ADDR_W); i++) rom[i] = DATA_W'(i * 37 + 5);
    rom[12'h0A5] = 12'hF0F;
    cur_addr = {12'h333, 12'h0A5, 12'h111, 12'h010};
    bus.addr = cur_addr;
    bus.req  = 4'hF;

    // Reset held with every request up: nothing granted, nothing returned.
    repeat (2) @(negedge clk60MHz);
    check("rst_gnt", 32'(bus.gnt), 32'(0));
    check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("rst_ovr", 32'(bus.starve_ovr), 32'(0));
    check("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
    @(posedge clk60MHz); #1;
    rst_n = 1'b1;

    vt.push_back('{4'b1111, 4'b0001, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0});
    vt.push_back('{4'b1110, 4'b0010, 1'b0});
    vt.push_back('{4'b1110, 4'b0100, 1'b0});
    vt.push_back('{4'b1110, 4'b1000, 1'b0});
    vt.push_back('{4'b1110, 4'b0010, 1'b0});
    vt.push_back('{4'b1110, 4'b0100, 1'b0});
    vt.push_back('{4'b1110, 4'b1000, 1'b0});
    vt.push_back('{4'b0100, 4'b0100, 1'b0});  // rom[0x0A5] = 0xF0F returns next cycle
    vt.push_back('{4'b0000, 4'b0000, 1'b0});
    vt.push_back('{4'b0110, 4'b0010, 1'b0});  // rr_ptr=3 wraps to 1
    vt.push_back('{4'b0100, 4'b0100, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0});
    for (int k = 0; k < STARVE_MAX; k++) vt.push_back('{4'b0101, 4'b0001, 1'b0});
    vt.push_back('{4'b0101, 4'b0100, 1'b1});
    vt.push_back('{4'b0101, 4'b0001, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0});
    for (int k = 0; k < vt.size(); k++)
      step(vt[k].req, vt[k].gnt, vt[k].ovr, $sformatf("vec%0d", k));

    // Streaming: 64 back-to-back reads by the pixel path.
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) check("stream_gap", 32'(bus.rd_valid), 32'(4'b0001));
      cur_addr[0] = ADDR_W'(i);
      step(4'b0001, 4'b0001, 1'b0, "stream");
    end
    step(4'b0000, 4'b0000, 1'b0, "stream_end");
    check("stream_pops", 32'(pops - p0), 32'(64));
    check("sb_drained", 32'(sb.size()), 32'(0));

    // Async reset while a requester-1 read is in flight.
    bus.req = 4'b0010;
    @(negedge clk60MHz);
    check("pre_rst_gnt", 32'(bus.gnt), 32'(4'b0010));
    @(posedge clk60MHz); #1;
    bus.req = 4'b0000;
    check("rst_pending", 32'(bus.rd_valid), 32'(4'b0010));
    #1 rst_n = 1'b0;
    #1 check("rst_async_rd_valid", 32'(bus.rd_valid), 32'(0));
    repeat (2) begin
      @(negedge clk60MHz);
      check("rst_hold_rd_valid", 32'(bus.rd_valid), 32'(0));
    end
    @(posedge clk60MHz); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk60MHz);
      check("rst_no_pulse", 32'(bus.rd_valid), 32'(0));
    end
    @(posedge clk60MHz); #1;
    // Requester 1 just won, so only a reset pointer picks 1 over 3 here.
    step(4'b1010, 4'b0010, 1'b0, "rst_ptr");
    step(4'b0000, 4'b0000, 1'b0, "tail");
    check("sb_final", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
